tdm_demux32: RTL and testbench
==============================

# tdm_demux32

Time-division demultiplexer that receives a serial bit stream produced by the 32:1 select-counter mux path and rebuilds the 32 parallel channel bits. It tracks channel position with a select counter, which is the inverse of the mux select. It locks to a frame-sync marker on channel 0 and delivers each complete frame as one word over a valid/ready handshake. It sits at the receive end of the serial link, between the link input and the parallel consumer logic.

## Interface
- N_CH, 32, channel count per frame; power of two, 2..32
- SEL_W, $clog2(N_CH), width of the channel select counter
- clk  input  1  sole clock; everything updates on the rising edge
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk
- in_valid  input  1  in_bit/in_sync are valid this cycle
- in_bit  input  1  serial data bit for the current channel
- in_sync  input  1  marks this bit as channel 0 of a frame
- in_ready  output  1  block accepts a bit this cycle
- out_word  output  N_CH  frame; channel i in out_word[i]
- out_valid  output  1  out_word holds an unconsumed frame
- out_ready  input  1  consumer takes out_word
- sel  output  SEL_W  channel index the next accepted bit is written to
- sync_err  output  1  one-cycle pulse on a framing error

## Operation
- Accept: in_valid && in_ready at a rising edge.
- States:
  - HUNT: in_ready=1. Bits accepted without in_sync are dropped silently. A bit accepted with in_sync is written to channel 0, sets sel=1, and moves to FILL.
  - FILL: in_ready=1. Each accepted bit is written to the collect buffer at index sel, then sel increments.
  - HOLD: in_ready=0. Entered when a frame is complete but the output register is still occupied.
- Sync rules in FILL:
  - in_sync with sel≠0: pulse sync_err, discard the partial frame, write this bit as channel 0, set sel=1, stay in FILL.
  - in_sync=0 with sel==0: pulse sync_err, drop the bit, go to HUNT.
- Frame completion, on accepting channel N_CH-1:
  - sel wraps to 0.
  - If out_valid==0, or out_valid && out_ready in the same cycle: copy the buffer to out_word, set out_valid=1, stay in FILL.
  - Otherwise go to HOLD.
- HOLD exit: the cycle out_ready is high, copy the buffer to out_word, keep out_valid=1, return to FILL with sel=0.
- out_valid clears on out_ready unless a new frame loads on the same edge; a same-edge load takes priority.
- out_word is stable while out_valid && !out_ready.
- Reset values: state HUNT, sel=0, collect buffer 0, out_word 0, out_valid 0, sync_err 0, in_ready 1.
- rst_n low mid-frame or in HOLD: the partial frame and any pending out_word are discarded; reset takes priority over all other events.

## Timing
- in_ready is combinational from state only: high in HUNT and FILL, low in HOLD.
- Latency: last bit accepted at edge k → out_valid=1 and out_word valid in the cycle after edge k.
- Throughput: one bit per cycle, so one frame every N_CH cycles with no bubbles while the consumer keeps pace.
- HOLD adds exactly the number of stall cycles until out_ready rises.
- sync_err is registered and high for exactly one cycle per error.

## Structure
- Package tdm_pkg: state enum (HUNT, FILL, HOLD) and the N_CH default constant.
- One sub-module, tdm_sel_counter: SEL_W-bit counter with clear, load-to-1, and increment-with-wrap, driving sel.
- Buffer writes decode sel one-hot, mirroring the mux select.

## Test plan
- Aligned frames: after reset, drive 3 back-to-back frames, each with sync on the first bit, out_ready=1, patterns 0xDEADBEEF, 0x00000001, 0x80000000 → three out_valid pulses carrying those words, each one cycle after its last bit, no sync_err.
- Hunt: 5 bits without sync, then frame 0x12345678 → first 5 bits dropped, out_word=0x12345678, no sync_err.
- Early sync: in_sync at channel 10 of a frame, then a full frame 0xA5A5A5A5 → sync_err once, only 0xA5A5A5A5 delivered.
- Missing sync: frame 0x0F0F0F0F, then the next bit arrives with in_sync=0 → sync_err once, state returns to HUNT, only 0x0F0F0F0F delivered.
- Backpressure: out_ready=0 across 2 full frames → in_ready falls on the edge that completes frame 2. Raising out_ready for one cycle swaps out_word from frame 1 to frame 2 with out_valid held high, and in_ready returns the next cycle.
- Reset mid-frame: rst_n low at channel 20 with out_valid=1 → next cycle out_valid=0, out_word=0, sel=0, state HUNT.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and defaults for the TDM receive demultiplexer.
package tdm_pkg;

   localparam int unsigned N_CH_DEF = 32;

   typedef enum logic [1:0] {
      HUNT = 2'd0,
      FILL = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/tdm_sel_counter.sv
// Channel select counter: clear, load-to-1 (after a channel 0 write) and
// increment with natural wrap at the power-of-two channel count.
module tdm_sel_counter
   import tdm_pkg::*;
#(
   parameter int unsigned SEL_W = $clog2(N_CH_DEF)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_load1,
   input  logic             i_inc,
   output logic [SEL_W-1:0] o_sel
);

   logic [SEL_W-1:0] r_sel;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sel <= '0;
      end else if (i_clr) begin
         r_sel <= '0;
      end else if (i_load1) begin
         r_sel <= SEL_W'(1);
      end else if (i_inc) begin
         r_sel <= r_sel + SEL_W'(1);
      end
   end

   assign o_sel = r_sel;

endmodule

// File: rtl/tdm_demux32.sv
// Serial-to-parallel TDM demultiplexer: locks to the channel 0 sync marker,
// rebuilds each frame and hands it out over a valid/ready register.
module tdm_demux32
   import tdm_pkg::*;
#(
   parameter int unsigned N_CH  = N_CH_DEF,
   parameter int unsigned SEL_W = $clog2(N_CH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             in_sync,
   output logic             in_ready,
   output logic [N_CH-1:0]  out_word,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SEL_W-1:0] sel,
   output logic             sync_err
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [N_CH-1:0]   r_buf;
   logic [N_CH-1:0]   w_buf_nxt;
   logic [N_CH-1:0]   w_onehot;
   logic [N_CH-1:0]   r_out_word;
   logic              r_out_valid;
   logic              r_sync_err;
   logic [SEL_W-1:0]  w_sel;
   logic [SEL_W-1:0]  w_wr_idx;
   logic              w_accept;
   logic              w_last;
   logic              w_sel_clr;
   logic              w_sel_load1;
   logic              w_sel_inc;
   logic              w_buf_wr;
   logic              w_buf_clr;
   logic              w_out_load;
   logic              w_sync_err;

   assign in_ready = (r_state != HOLD);
   assign w_accept = in_valid && in_ready;
   assign w_last   = (w_sel == SEL_W'(N_CH - 1));

   tdm_sel_counter #(
      .SEL_W (SEL_W)
   ) u_sel_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (w_sel_clr),
      .i_load1 (w_sel_load1),
      .i_inc   (w_sel_inc),
      .o_sel   (w_sel)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= HUNT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state plus the per-cycle buffer, counter and output controls.
   always_comb begin
      w_state_nxt = r_state;
      w_sel_clr   = 1'b0;
      w_sel_load1 = 1'b0;
      w_sel_inc   = 1'b0;
      w_buf_wr    = 1'b0;
      w_buf_clr   = 1'b0;
      w_wr_idx    = w_sel;
      w_out_load  = 1'b0;
      w_sync_err  = 1'b0;
      case (r_state)
         HUNT: begin
            if (w_accept && in_sync) begin
               w_buf_wr    = 1'b1;
               w_buf_clr   = 1'b1;
               w_wr_idx    = '0;
               w_sel_load1 = 1'b1;
               w_state_nxt = FILL;
            end
         end
         FILL: begin
            if (w_accept) begin
               if (in_sync && (w_sel != '0)) begin
                  // Early marker: restart the frame from this bit.
                  w_sync_err  = 1'b1;
                  w_buf_wr    = 1'b1;
                  w_buf_clr   = 1'b1;
                  w_wr_idx    = '0;
                  w_sel_load1 = 1'b1;
               end else if (!in_sync && (w_sel == '0)) begin
                  w_sync_err  = 1'b1;
                  w_sel_clr   = 1'b1;
                  w_state_nxt = HUNT;
               end else begin
                  w_buf_wr  = 1'b1;
                  w_sel_inc = 1'b1;
                  if (w_last) begin
                     if (!r_out_valid || out_ready) begin
                        w_out_load = 1'b1;
                     end else begin
                        w_state_nxt = HOLD;
                     end
                  end
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               w_out_load  = 1'b1;
               w_state_nxt = FILL;
            end
         end
         default: begin
            w_state_nxt = HUNT;
         end
      endcase
   end

   // One-hot decode of the write index, matching the mux select.
   always_comb begin
      w_onehot  = N_CH'(1) << w_wr_idx;
      w_buf_nxt = r_buf;
      if (w_buf_wr) begin
         w_buf_nxt = (w_buf_clr ? '0 : (r_buf & ~w_onehot)) |
                     (in_bit ? w_onehot : '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_buf       <= '0;
         r_out_word  <= '0;
         r_out_valid <= 1'b0;
         r_sync_err  <= 1'b0;
      end else begin
         r_buf      <= w_buf_nxt;
         r_sync_err <= w_sync_err;
         if (w_out_load) begin
            r_out_word  <= w_buf_nxt;
            r_out_valid <= 1'b1;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_word  = r_out_word;
   assign out_valid = r_out_valid;
   assign sel       = w_sel;
   assign sync_err  = r_sync_err;

endmodule

// File: tb/tb_tdm_demux32.sv
// Bench for tdm_demux32: vector table for frame delivery plus hand-written
// sequences for missing sync, backpressure and mid-frame reset.
module tb_tdm_demux32;

   localparam int unsigned N = 32;

   typedef struct {
      bit          rst;
      int unsigned junk;
      int unsigned abort_at;
      logic [N-1:0] word;
      int unsigned exp_err;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_bit;
   logic          in_sync;
   logic          in_ready;
   logic [N-1:0]  out_word;
   logic          out_valid;
   logic          out_ready;
   logic [4:0]    sel;
   logic          sync_err;

   int            errors = 0;
   int            checks = 0;
   int            err_pulses = 0;
   logic [N-1:0]  sb_q[$];
   logic [N-1:0]  mon_exp;
   vec_t          vecs[5];

   tdm_demux32 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .in_sync   (in_sync),
      .in_ready  (in_ready),
      .out_word  (out_word),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sel       (sel),
      .sync_err  (sync_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [N-1:0] act,
                      input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: every handshake must deliver the oldest expected frame.
   always @(negedge clk) begin
      if (sync_err === 1'b1) err_pulses++;
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got %h expected no frame", out_word);
         end else begin
            mon_exp = sb_q.pop_front();
            chk("sb_word", out_word, mon_exp);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input logic s);
      in_valid = 1'b1;
      in_bit   = b;
      in_sync  = s;
      tick();
      in_valid = 1'b0;
      in_bit   = 1'b0;
      in_sync  = 1'b0;
   endtask

   task automatic send_part(input logic [N-1:0] w, input int first, input int count);
      for (int c = first; c < first + count; c++) begin
         send_bit(w[c], 1'(c == 0));
      end
   endtask

   task automatic send_frame(input logic [N-1:0] w);
      sb_q.push_back(w);
      send_part(w, 0, N);
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      sb_q.delete();
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_bit    = 1'b0;
      in_sync   = 1'b0;
      out_ready = 1'b1;
      vecs[0] = '{rst: 1'b1, junk: 0, abort_at: 0,  word: 32'hDEADBEEF, exp_err: 0};
      vecs[1] = '{rst: 1'b0, junk: 0, abort_at: 0,  word: 32'h00000001, exp_err: 0};
      vecs[2] = '{rst: 1'b0, junk: 0, abort_at: 0,  word: 32'h80000000, exp_err: 0};
      vecs[3] = '{rst: 1'b1, junk: 5, abort_at: 0,  word: 32'h12345678, exp_err: 0};
      vecs[4] = '{rst: 1'b0, junk: 0, abort_at: 10, word: 32'hA5A5A5A5, exp_err: 1};

      tick();
      tick();
      chk("rst_out_valid", N'(out_valid), N'(0));
      chk("rst_out_word", out_word, '0);
      chk("rst_sel", N'(sel), N'(0));
      chk("rst_sync_err", N'(sync_err), N'(0));
      chk("rst_in_ready", N'(in_ready), N'(1));
      rst_n = 1'b1;

      // Table: optional reset, junk bits in HUNT, optional aborted partial frame.
      for (int i = 0; i < 5; i++) begin
         if (vecs[i].rst) do_reset();
         err_pulses = 0;
         for (int j = 0; j < int'(vecs[i].junk); j++) send_bit(1'($urandom_range(0, 1)), 1'b0);
         if (vecs[i].abort_at != 0) begin
            send_bit(1'b1, 1'b1);
            for (int j = 1; j < int'(vecs[i].abort_at); j++) send_bit(1'($urandom_range(0, 1)), 1'b0);
         end
         send_frame(vecs[i].word);
         chk($sformatf("v%0d_lat_valid", i), N'(out_valid), N'(1));
         chk($sformatf("v%0d_word", i), out_word, vecs[i].word);
         tick();
         tick();
         chk($sformatf("v%0d_sync_err_cnt", i), N'(err_pulses), N'(vecs[i].exp_err));
      end

      // Missing sync: a non-sync bit at channel 0 drops back to HUNT.
      err_pulses = 0;
      send_frame(32'h0F0F0F0F);
      chk("ms_word", out_word, 32'h0F0F0F0F);
      send_bit(1'b1, 1'b0);
      tick();
      chk("ms_err_once", N'(err_pulses), N'(1));
      chk("ms_sel", N'(sel), N'(0));
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      tick();
      chk("ms_hunt_silent", N'(err_pulses), N'(1));
      chk("ms_sb_empty", N'(sb_q.size()), N'(0));

      // Backpressure: second frame stalls in HOLD until out_ready rises.
      do_reset();
      out_ready = 1'b0;
      send_frame(32'h11112222);
      chk("bp_f1_valid", N'(out_valid), N'(1));
      chk("bp_f1_word", out_word, 32'h11112222);
      sb_q.push_back(32'h33334444);
      send_part(32'h33334444, 0, N - 1);
      chk("bp_ready_before", N'(in_ready), N'(1));
      send_part(32'h33334444, N - 1, 1);
      chk("bp_ready_low", N'(in_ready), N'(0));
      chk("bp_word_hold", out_word, 32'h11112222);
      tick();
      tick();
      chk("bp_word_stable", out_word, 32'h11112222);
      chk("bp_ready_still_low", N'(in_ready), N'(0));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_swap_word", out_word, 32'h33334444);
      chk("bp_swap_valid", N'(out_valid), N'(1));
      chk("bp_ready_back", N'(in_ready), N'(1));
      out_ready = 1'b1;
      tick();
      chk("bp_drained", N'(out_valid), N'(0));

      // Reset mid-frame with a pending output word.
      out_ready = 1'b0;
      send_frame(32'hCAFEF00D);
      send_part(32'h5555AAAA, 0, 20);
      chk("mr_sel_mid", N'(sel), N'(20));
      chk("mr_valid_before", N'(out_valid), N'(1));
      rst_n = 1'b0;
      tick();
      chk("mr_out_valid", N'(out_valid), N'(0));
      chk("mr_out_word", out_word, '0);
      chk("mr_sel", N'(sel), N'(0));
      chk("mr_in_ready", N'(in_ready), N'(1));
      rst_n = 1'b1;
      sb_q.delete();
      err_pulses = 0;
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      tick();
      chk("mr_hunt_no_err", N'(err_pulses), N'(0));
      chk("mr_hunt_sel", N'(sel), N'(0));
      out_ready = 1'b1;
      tick();

      chk("sb_drain", N'(sb_q.size()), N'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
